// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Time-shares the single external SRAM between NUM_PORTS masters (CPU data,
// VGA fetch, audio, timer/DMA). Each access is one req/ack transaction:
//   IDLE   : pick a winner, latch its address/data/direction
//   ACCESS : strobes asserted for RD_LAT (read) or WR_LAT (write) cycles
//   DONE   : strobes released, one-cycle ack to the winner
// so back-to-back accesses are L+2 cycles apart.
//
// Arbitration is round-robin starting after the last served port.
// Optional build macro SRAM_ARB_PORT0_PRIO_EN: port 0 (VGA fetch) always
// wins when requesting; the remaining ports rotate among themselves.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req/we               per-port request level and write(1)/read(0) select
//   addr/wdata           per-port address/write data, port p at [p*W +: W]
//   ack                  one-hot completion pulse
//   rdata                read data shared by all ports, held until next read
//   busy                 high whenever the FSM is not idle
//   gnt_id               index of the currently granted port
//   sram_ce_n/oe_n/we_n  active-low SRAM strobes
//   sram_addr/sram_din   address and data driven to the SRAM
//   sram_dout            data returned from the SRAM
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int DW        = 16,
    parameter int AW        = 16,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [NUM_PORTS-1:0]         we,
    input  logic [NUM_PORTS*AW-1:0]      addr,
    input  logic [NUM_PORTS*DW-1:0]      wdata,
    output logic [NUM_PORTS-1:0]         ack,
    output logic [DW-1:0]                rdata,
    output logic                         busy,
    output logic [$clog2(NUM_PORTS)-1:0] gnt_id,
    output logic                         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic [AW-1:0]                sram_addr,
    output logic [DW-1:0]                sram_din,
    input  logic [DW-1:0]                sram_dout
);

    localparam int GW     = $clog2(NUM_PORTS);
    localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [GW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic            we_l;
    logic            win_vld;
    logic [GW-1:0]   win_id;
    logic [GW-1:0]   scan_id;
    int              scan_idx;

    // Round-robin winner. Offsets are scanned from the lowest priority
    // (last itself) up to the highest (last+1) so that the final assignment
    // is the first requester after last.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = 0;
        scan_id  = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            scan_idx = int'(last) + i;
            if (scan_idx >= NUM_PORTS) begin
                scan_idx = scan_idx - NUM_PORTS;
            end
            scan_id = GW'(scan_idx);
            if (req[scan_id]) begin
                win_vld = 1'b1;
                win_id  = scan_id;
            end
        end
`ifdef SRAM_ARB_PORT0_PRIO_EN
        if (req[0]) begin
            win_vld = 1'b1;
            win_id  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Strobes and ack decode straight from the state register, so an
    // asynchronous reset releases the SRAM immediately without a clock edge.
    // Output enable follows the latched direction: low for reads only.
    always_comb begin
        state_nx  = state;
        ack       = '0;
        busy      = 1'b1;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_vld) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                sram_ce_n = 1'b0;
                sram_oe_n = we_l;
                sram_we_n = !we_l;
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                ack[gnt_id] = 1'b1;
                state_nx    = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id    <= '0;
            last      <= GW'(NUM_PORTS - 1);
            we_l      <= 1'b0;
            cnt       <= '0;
            sram_addr <= '0;
            sram_din  <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt_id    <= win_id;
                        we_l      <= we[win_id];
                        sram_addr <= addr[int'(win_id)*AW +: AW];
                        sram_din  <= wdata[int'(win_id)*DW +: DW];
                        cnt       <= we[win_id] ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
                    end
                end
                ACCESS: begin
                    // Counter at zero marks the last strobe cycle; read data
                    // is sampled on the same edge that moves to DONE.
                    if (cnt == '0) begin
                        if (!we_l) begin
                            rdata <= sram_dout;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
`ifdef SRAM_ARB_PORT0_PRIO_EN
                    // Port 0 sits outside the rotation.
                    if (gnt_id != '0) begin
                        last <= gnt_id;
                    end
`else
                    last <= gnt_id;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with NUM_PORTS=3, DW=AW=16, RD_LAT=2,
// WR_LAT=1. The SRAM model returns 0xBEEF at address 0x0040 and
// addr ^ 0x5A5A everywhere else. A table of single transactions is replayed,
// followed by hand-written round-robin, mid-access reset, requester-drop and
// port-0 priority sequences.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int NP = 3;
    localparam int RL = 2;
    localparam int WL = 1;

    logic            clk;
    logic            rst_n;
    logic [NP-1:0]   req;
    logic [NP-1:0]   we;
    logic [NP*16-1:0] addr;
    logic [NP*16-1:0] wdata;
    logic [NP-1:0]   ack;
    logic [15:0]     rdata;
    logic            busy;
    logic [1:0]      gnt_id;
    logic            sram_ce_n;
    logic            sram_oe_n;
    logic            sram_we_n;
    logic [15:0]     sram_addr;
    logic [15:0]     sram_din;
    logic [15:0]     sram_dout;

    int checks;
    int errors;
    int ack_ids[$];
    int ack_cyc[$];

    sram_arbiter #(
        .NUM_PORTS(NP), .DW(16), .AW(16), .RD_LAT(RL), .WR_LAT(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy),
        .gnt_id(gnt_id), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    assign sram_dout = (sram_addr == 16'h0040) ? 16'hBEEF : (sram_addr ^ 16'h5A5A);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [2:0]  exp_ack;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_port(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
        we[p]          = w;
        addr[p*16 +: 16]  = a;
        wdata[p*16 +: 16] = d;
    endtask

    // Waits for n acks within budget cycles, recording port index and cycle.
    task automatic collect(input int n, input int budget, input string tag);
        int cyc;
        ack_ids.delete();
        ack_cyc.delete();
        cyc = 0;
        while (ack_ids.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                chk({tag, " ack onehot"}, 32'($onehot(ack)), 32'd1);
                for (int p = 0; p < NP; p++) begin
                    if (ack[p]) ack_ids.push_back(p);
                end
                ack_cyc.push_back(cyc);
            end
        end
        chk({tag, " ack count"}, 32'(ack_ids.size()), 32'(n));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat, ce_cnt, oe_cnt, we_cnt, ack_cnt, ack_at;
        logic [2:0]  ack_val;
        logic [15:0] seen_addr, seen_din;
        string tag;
        tag = $sformatf("vec%0d", idx);
        lat = v.wr ? WL : RL;
        ce_cnt = 0; oe_cnt = 0; we_cnt = 0; ack_cnt = 0; ack_at = 0;
        ack_val = '0; seen_addr = '0; seen_din = '0;
        set_port(v.port, v.wr, v.a, v.d);
        req[v.port] = 1'b1;
        for (int n = 1; n <= lat + 4; n++) begin
            @(negedge clk);
            if (!sram_ce_n) begin
                ce_cnt++;
                seen_addr = sram_addr;
                seen_din  = sram_din;
            end
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (ack != '0) begin
                ack_cnt++;
                ack_val = ack;
                ack_at  = n;
                req[v.port] = 1'b0;
            end
        end
        chk({tag, " ce cycles"}, 32'(ce_cnt), 32'(lat));
        chk({tag, " oe cycles"}, 32'(oe_cnt), v.wr ? 32'd0 : 32'(lat));
        chk({tag, " we cycles"}, 32'(we_cnt), v.wr ? 32'(lat) : 32'd0);
        chk({tag, " sram addr"}, 32'(seen_addr), 32'(v.a));
        if (v.wr) chk({tag, " sram din"}, 32'(seen_din), 32'(v.d));
        chk({tag, " ack value"}, 32'(ack_val), 32'(v.exp_ack));
        chk({tag, " ack pulses"}, 32'(ack_cnt), 32'd1);
        chk({tag, " ack latency"}, 32'(ack_at), 32'(lat + 1));
        chk({tag, " rdata"}, 32'(rdata), 32'(v.exp_rdata));
        chk({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        we     = '0;
        addr   = '0;
        wdata  = '0;

        //          port wr  addr      wdata     ack     rdata
        vecs[0] = '{1, 1'b0, 16'h0040, 16'h0000, 3'b010, 16'hBEEF};
        vecs[1] = '{2, 1'b1, 16'h00FF, 16'h1234, 3'b100, 16'hBEEF};
        vecs[2] = '{0, 1'b0, 16'h1234, 16'h0000, 3'b001, 16'h486E};
        vecs[3] = '{2, 1'b0, 16'hFFFF, 16'h0000, 3'b100, 16'hA5A5};
        vecs[4] = '{0, 1'b1, 16'h0000, 16'hFFFF, 3'b001, 16'hA5A5};
        vecs[5] = '{1, 1'b0, 16'h8001, 16'h0000, 3'b010, 16'hDA5B};

        do_reset();
        @(negedge clk);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset gnt_id", 32'(gnt_id), 32'd0);
        chk("reset strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("reset sram_addr", 32'(sram_addr), 32'd0);
        chk("reset sram_din", 32'(sram_din), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Round-robin: all ports requesting continuously from reset.
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, 16'h0100 + 16'(p), 16'h0000);
        req = 3'b111;
        collect(6, 60, "rr");
        req = '0;
        for (int i = 0; i < ack_ids.size(); i++) begin
            chk($sformatf("rr order %0d", i), 32'(ack_ids[i]), 32'(i % NP));
        end
        for (int i = 1; i < ack_cyc.size(); i++) begin
            chk($sformatf("rr spacing %0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(RL + 2));
        end
        repeat (6) @(negedge clk);

        // Reset mid-access: serve port 0 first so port 1 wins the next round.
        run_vec(6, vecs[2]);
        set_port(0, 1'b0, 16'h0200, 16'h0000);
        set_port(1, 1'b0, 16'h0201, 16'h0000);
        req = 3'b011;
        @(negedge clk);
        @(negedge clk);
        chk("midrst in access", 32'(sram_ce_n), 32'd0);
        chk("midrst grant", 32'(gnt_id), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("midrst ack", 32'(ack), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("midrst held ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        collect(1, 10, "midrst");
        req = '0;
        if (ack_ids.size() > 0) chk("midrst first winner", 32'(ack_ids[0]), 32'd0);
        repeat (4) @(negedge clk);

        // Requester drops req during ACCESS.
        set_port(0, 1'b0, 16'h0040, 16'h0000);
        req[0] = 1'b1;
        @(negedge clk);
        chk("drop busy", 32'(busy), 32'd1);
        req[0] = 1'b0;
        collect(1, 10, "drop");
        if (ack_ids.size() > 0) chk("drop ack port", 32'(ack_ids[0]), 32'd0);
        chk("drop rdata", 32'(rdata), 32'hBEEF);
        @(negedge clk);
        chk("drop idle", 32'(busy), 32'd0);

        // Ports 0 and 1 requesting continuously.
        do_reset();
        set_port(0, 1'b0, 16'h0300, 16'h0000);
        set_port(1, 1'b0, 16'h0301, 16'h0000);
        req = 3'b011;
        collect(4, 40, "prio");
        req = '0;
        for (int i = 0; i < ack_ids.size(); i++) begin
`ifdef SRAM_ARB_PORT0_PRIO_EN
            chk($sformatf("prio order %0d", i), 32'(ack_ids[i]), 32'd0);
`else
            chk($sformatf("prio order %0d", i), 32'(ack_ids[i]), 32'(i % 2));
`endif
        end
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
